// File: rtl/alu_pwr_pkg.sv
// Shared types and default constants for the ALU power/clock-gating sequencer.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    PWR_RUN     = 3'd0,
    PWR_CLAMP   = 3'd1,
    PWR_GATED   = 3'd2,
    PWR_UNGATE  = 3'd3,
    PWR_UNCLAMP = 3'd4
  } pwr_state_t;

  localparam int unsigned DEF_IDLE_CYCLES   = 16;
  localparam int unsigned DEF_CLAMP_SETTLE  = 2;
  localparam int unsigned DEF_UNGATE_SETTLE = 4;
  localparam int unsigned DEF_STAT_W        = 16;

  // The single window counter is shared by the idle and both settle windows,
  // so it must hold the largest load value of the three.
  function automatic int unsigned cnt_width(input int unsigned idle_cycles,
                                            input int unsigned ungate_settle,
                                            input int unsigned clamp_settle);
    int unsigned m;
    m = (idle_cycles > ungate_settle) ? idle_cycles : ungate_settle;
    m = (clamp_settle > m) ? clamp_settle : m;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned DEF_CNT_W =
    cnt_width(DEF_IDLE_CYCLES, DEF_UNGATE_SETTLE, DEF_CLAMP_SETTLE);

endpackage

// File: rtl/alu_pwr_cnt.sv
// Loadable saturating down-counter with a done flag (count == 0).
module alu_pwr_cnt #(
  parameter int unsigned  W       = 5,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// ALU clock-dissolve sequencer: clamps before gating, ungates before unclamping.
// Optional statistics counters are built only when ALU_PWR_STATS_EN is defined.
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES   = DEF_IDLE_CYCLES,
  parameter int unsigned CLAMP_SETTLE  = DEF_CLAMP_SETTLE,
  parameter int unsigned UNGATE_SETTLE = DEF_UNGATE_SETTLE,
  parameter int unsigned STAT_W        = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic              sleep_req,
  input  logic              wake_req,
  input  logic              alu_busy,
  output logic              start_out,
  output logic              ready,
  output logic              diss_clk,
  output logic              clamp_en,
  output logic [2:0]        pwr_state,
  output logic [STAT_W-1:0] gate_events,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam int unsigned CNT_W = cnt_width(IDLE_CYCLES, UNGATE_SETTLE, CLAMP_SETTLE);
  localparam logic [CNT_W-1:0] IDLE_LOAD   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLAMP_LOAD  = CNT_W'(CLAMP_SETTLE - 1);
  localparam logic [CNT_W-1:0] UNGATE_LOAD = CNT_W'(UNGATE_SETTLE - 1);

  // Handshake: an op transfers on a cycle where start_in && ready; the requester
  // holds start_in until then, so ops raised outside RUN wait for the first RUN cycle.

  pwr_state_t       r_state;
  pwr_state_t       w_next;
  logic             r_ready;
  logic             r_diss;
  logic             r_clamp;
  logic             w_idle;
  logic             w_wake;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_cnt_done;

  assign w_idle = !alu_busy && !start_in;
  assign w_wake = start_in || wake_req;

  // In RUN the counter holds the idle cycles still needed; a fresh window is full.
  alu_pwr_cnt #(
    .W       (CNT_W),
    .RST_VAL (IDLE_LOAD)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_done     (w_cnt_done)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = IDLE_LOAD;
    w_dec      = 1'b0;
    unique case (r_state)
      PWR_RUN: begin
        if (w_idle && (w_cnt_done || sleep_req)) begin
          w_next     = PWR_CLAMP;
          w_load     = 1'b1;
          w_load_val = CLAMP_LOAD;
        end else if (!w_idle) begin
          w_load = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      PWR_CLAMP: begin
        if (w_wake) begin
          w_next = PWR_UNCLAMP;
        end else if (w_cnt_done) begin
          w_next = PWR_GATED;
        end else begin
          w_dec = 1'b1;
        end
      end
      PWR_GATED: begin
        if (w_wake) begin
          w_next     = PWR_UNGATE;
          w_load     = 1'b1;
          w_load_val = UNGATE_LOAD;
        end
      end
      PWR_UNGATE: begin
        if (w_cnt_done) w_next = PWR_UNCLAMP;
        else            w_dec  = 1'b1;
      end
      PWR_UNCLAMP: begin
        w_next = PWR_RUN;
        w_load = 1'b1;
      end
      default: begin
        w_next = PWR_RUN;
        w_load = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state into flops so diss_clk never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= PWR_RUN;
      r_ready <= 1'b1;
      r_diss  <= 1'b0;
      r_clamp <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == PWR_RUN);
      r_diss  <= (w_next == PWR_GATED);
      r_clamp <= (w_next == PWR_CLAMP) || (w_next == PWR_GATED) || (w_next == PWR_UNGATE);
    end
  end

  assign ready     = r_ready;
  assign diss_clk  = r_diss;
  assign clamp_en  = r_clamp;
  assign pwr_state = r_state;
  assign start_out = start_in && r_ready;

`ifdef ALU_PWR_STATS_EN
  logic              w_gate_entry;
  logic [STAT_W-1:0] r_gate_events;
  logic [STAT_W-1:0] r_gated_cycles;

  assign w_gate_entry = (r_state == PWR_CLAMP) && (w_next == PWR_GATED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gate_events  <= '0;
      r_gated_cycles <= '0;
    end else begin
      if (w_gate_entry && (r_gate_events != '1))
        r_gate_events <= r_gate_events + STAT_W'(1);
      if ((r_state == PWR_GATED) && (r_gated_cycles != '1))
        r_gated_cycles <= r_gated_cycles + STAT_W'(1);
    end
  end

  assign gate_events  = r_gate_events;
  assign gated_cycles = r_gated_cycles;
`else
  assign gate_events  = '0;
  assign gated_cycles = '0;
`endif

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq: per-cycle vector table plus hand-written
// auto-gate, wake-by-op, mid-sequence reset and statistics sequences.
module tb_alu_pwr_seq;

  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_in;
  logic              sleep_req;
  logic              wake_req;
  logic              alu_busy;
  logic              start_out;
  logic              ready;
  logic              diss_clk;
  logic              clamp_en;
  logic [2:0]        pwr_state;
  logic [STAT_W-1:0] gate_events;
  logic [STAT_W-1:0] gated_cycles;

  int n_total = 0;
  int n_pass  = 0;

`ifdef ALU_PWR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Expected {ready, diss_clk, clamp_en, pwr_state[2:0], start_out}
  localparam logic [6:0] E_RUN     = 7'b1000000;
  localparam logic [6:0] E_RUN_SO  = 7'b1000001;
  localparam logic [6:0] E_CLAMP   = 7'b0010010;
  localparam logic [6:0] E_GATED   = 7'b0110100;
  localparam logic [6:0] E_UNGATE  = 7'b0010110;
  localparam logic [6:0] E_UNCLAMP = 7'b0001000;

  typedef struct {
    logic       s;
    logic       sl;
    logic       w;
    logic       b;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  alu_pwr_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start_in),
    .sleep_req    (sleep_req),
    .wake_req     (wake_req),
    .alu_busy     (alu_busy),
    .start_out    (start_out),
    .ready        (ready),
    .diss_clk     (diss_clk),
    .clamp_en     (clamp_en),
    .pwr_state    (pwr_state),
    .gate_events  (gate_events),
    .gated_cycles (gated_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called at a falling edge: drive one cycle of inputs, check, move to the next falling edge.
  task automatic cyc(input string name, input logic s, input logic sl, input logic w,
                     input logic b, input logic [6:0] exp);
    start_in  = s;
    sleep_req = sl;
    wake_req  = w;
    alu_busy  = b;
    #1;
    chk(name, {25'd0, ready, diss_clk, clamp_en, pwr_state, start_out}, {25'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    start_in  = 1'b0;
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    alu_busy  = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One forced-sleep entry holding GATED for exactly 10 cycles, then full exit.
  task automatic gate_once();
    cyc("st_sleep", 1'b0, 1'b1, 1'b0, 1'b0, E_RUN);
    repeat (2) cyc("st_clamp", 1'b0, 1'b0, 1'b0, 1'b0, E_CLAMP);
    repeat (9) cyc("st_gated", 1'b0, 1'b0, 1'b0, 1'b0, E_GATED);
    cyc("st_gated_wake", 1'b0, 1'b0, 1'b1, 1'b0, E_GATED);
    repeat (4) cyc("st_ungate", 1'b0, 1'b0, 1'b0, 1'b0, E_UNGATE);
    cyc("st_unclamp", 1'b0, 1'b0, 1'b0, 1'b0, E_UNCLAMP);
    cyc("st_run", 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                s     sl    w     b     expected
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, E_RUN};     // sleep while busy: stay
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, E_RUN};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, E_RUN};     // busy drops: clamp next
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_CLAMP};   // abort on first CLAMP cycle
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_UNCLAMP};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, E_RUN_SO};  // start beats sleep
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, E_RUN};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, E_RUN_SO};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, E_RUN};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, E_CLAMP};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, E_CLAMP};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, E_GATED};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, E_GATED};   // sleep ignored in GATED
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, E_GATED};   // wake_req exit
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, E_UNGATE};  // wake ignored in UNGATE
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, E_UNGATE};  // held op waits
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, E_UNGATE};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, E_UNGATE};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, E_UNCLAMP};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, E_RUN_SO};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, E_RUN};

    do_reset(2);
    #1;
    chk("rst_gate_events", 32'(gate_events), 32'd0);
    chk("rst_gated_cycles", 32'(gated_cycles), 32'd0);

    // Idle from cycle 0: clamp at 16, gate at 18.
    for (int c = 0; c < 20; c++) begin
      cyc($sformatf("autogate_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0,
          (c < 16) ? E_RUN : ((c < 18) ? E_CLAMP : E_GATED));
    end

    // Wake by op at T (cycle 20).
    cyc("wake_T", 1'b1, 1'b0, 1'b0, 1'b0, E_GATED);
    for (int k = 1; k <= 4; k++)
      cyc($sformatf("wake_T+%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, E_UNGATE);
    cyc("wake_T+5", 1'b1, 1'b0, 1'b0, 1'b0, E_UNCLAMP);
    cyc("wake_T+6", 1'b1, 1'b0, 1'b0, 1'b0, E_RUN_SO);
    cyc("wake_T+7", 1'b0, 1'b0, 1'b0, 1'b1, E_RUN);

    for (int i = 0; i < 22; i++)
      cyc($sformatf("vec%0d", i), tbl[i].s, tbl[i].sl, tbl[i].w, tbl[i].b, tbl[i].exp);

    // Enter GATED once more, then reset in the middle of the sequence.
    cyc("mid_sleep", 1'b0, 1'b1, 1'b0, 1'b0, E_RUN);
    repeat (2) cyc("mid_clamp", 1'b0, 1'b0, 1'b0, 1'b0, E_CLAMP);
    start_in = 1'b0;
    #1;
    chk("mid_gated_state", {25'd0, ready, diss_clk, clamp_en, pwr_state, start_out}, {25'd0, E_GATED});
    chk("mid_gate_events", 32'(gate_events), STATS ? 32'd3 : 32'd0);
    chk("mid_gated_cycles", 32'(gated_cycles), STATS ? 32'd6 : 32'd0);
    @(negedge clk);
    do_reset(1);
    #1;
    chk("midrst_outputs", {25'd0, ready, diss_clk, clamp_en, pwr_state, start_out}, {25'd0, E_RUN});
    chk("midrst_gate_events", 32'(gate_events), 32'd0);
    chk("midrst_gated_cycles", 32'(gated_cycles), 32'd0);

    // Statistics: three entries of ten GATED cycles each.
    repeat (3) gate_once();
    #1;
    chk("stats_gate_events", 32'(gate_events), STATS ? 32'd3 : 32'd0);
    chk("stats_gated_cycles", 32'(gated_cycles), STATS ? 32'd30 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
